// File: rtl/ctrl_pipe_pkg.sv
// Shared opcode/function constants and per-stage control-word layouts for the
// pipelined CPU control path.
package ctrl_pipe_pkg;

   localparam logic [3:0] OPCODE_BNE   = 4'h0;
   localparam logic [3:0] OPCODE_BEQ   = 4'h1;
   localparam logic [3:0] OPCODE_BGZ   = 4'h2;
   localparam logic [3:0] OPCODE_BLZ   = 4'h3;
   localparam logic [3:0] OPCODE_ADI   = 4'h4;
   localparam logic [3:0] OPCODE_ORI   = 4'h5;
   localparam logic [3:0] OPCODE_LHI   = 4'h6;
   localparam logic [3:0] OPCODE_LWD   = 4'h7;
   localparam logic [3:0] OPCODE_SWD   = 4'h8;
   localparam logic [3:0] OPCODE_JMP   = 4'h9;
   localparam logic [3:0] OPCODE_JAL   = 4'hA;
   localparam logic [3:0] OPCODE_RTYPE = 4'hF;

   localparam logic [5:0] FUNC_ADD = 6'd0;
   localparam logic [5:0] FUNC_SUB = 6'd1;
   localparam logic [5:0] FUNC_AND = 6'd2;
   localparam logic [5:0] FUNC_ORR = 6'd3;
   localparam logic [5:0] FUNC_NOT = 6'd4;
   localparam logic [5:0] FUNC_TCP = 6'd5;
   localparam logic [5:0] FUNC_SHL = 6'd6;
   localparam logic [5:0] FUNC_SHR = 6'd7;
   localparam logic [5:0] FUNC_JPR = 6'd25;
   localparam logic [5:0] FUNC_JRL = 6'd26;
   localparam logic [5:0] FUNC_WWD = 6'd28;
   localparam logic [5:0] FUNC_HLT = 6'd29;

   localparam logic [1:0] PC_SRC_BRANCH = 2'd0;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd1;
   localparam logic [1:0] PC_SRC_REG    = 2'd2;

   localparam logic [1:0] REG_DST_RT   = 2'd0;
   localparam logic [1:0] REG_DST_RD   = 2'd1;
   localparam logic [1:0] REG_DST_LINK = 2'd2;

   // alu_op carries the opcode and func the R-type function field; both are
   // zero for bubbles and illegal words. An all-zero word is a bubble.
   typedef struct packed {
      logic       alu_src;
      logic [1:0] reg_dst;
      logic [1:0] pc_src;
      logic [3:0] alu_op;
      logic [5:0] func;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       link;
      logic       wwd;
      logic       halt;
      logic       illegal;
      logic       valid;
   } ex_ctrl_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
      logic link;
      logic wwd;
      logic halt;
      logic illegal;
      logic valid;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic link;
      logic wwd;
      logic halt;
      logic illegal;
      logic valid;
   } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: one instruction word to an EX control word
// plus an illegal flag. Illegal words decode as an all-zero NOP.
module ctrl_decode
   import ctrl_pipe_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 16
) (
   input  logic [WORD_SIZE-1:0] inst_i,
   output ex_ctrl_t             ctrl_o,
   output logic                 illegal_o
);

   logic [3:0] opcode;
   logic [5:0] func;
   logic       unused_inst;

   assign opcode      = inst_i[WORD_SIZE-1 -: 4];
   assign func        = inst_i[5:0];
   // Register-specifier bits are consumed by the datapath, not by control.
   assign unused_inst = ^inst_i[WORD_SIZE-5:6];

   always_comb begin
      ctrl_o    = '0;
      illegal_o = 1'b0;
      case (opcode)
         OPCODE_BNE, OPCODE_BEQ, OPCODE_BGZ, OPCODE_BLZ: begin
            ctrl_o.pc_src = PC_SRC_BRANCH;
         end
         OPCODE_ADI, OPCODE_ORI, OPCODE_LHI: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_dst   = REG_DST_RT;
            ctrl_o.reg_write = 1'b1;
         end
         OPCODE_LWD: begin
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.mem_read   = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
         end
         OPCODE_SWD: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.mem_write = 1'b1;
         end
         OPCODE_JMP: begin
            ctrl_o.pc_src = PC_SRC_JUMP;
         end
         OPCODE_JAL: begin
            ctrl_o.pc_src    = PC_SRC_JUMP;
            ctrl_o.reg_dst   = REG_DST_LINK;
            ctrl_o.link      = 1'b1;
            ctrl_o.reg_write = 1'b1;
         end
         OPCODE_RTYPE: begin
            ctrl_o.func = func;
            case (func)
               FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_ORR,
               FUNC_NOT, FUNC_TCP, FUNC_SHL, FUNC_SHR: begin
                  ctrl_o.reg_dst   = REG_DST_RD;
                  ctrl_o.reg_write = 1'b1;
               end
               FUNC_JPR: begin
                  ctrl_o.pc_src = PC_SRC_REG;
               end
               FUNC_JRL: begin
                  ctrl_o.pc_src    = PC_SRC_REG;
                  ctrl_o.reg_dst   = REG_DST_LINK;
                  ctrl_o.link      = 1'b1;
                  ctrl_o.reg_write = 1'b1;
               end
               FUNC_WWD: begin
                  ctrl_o.wwd = 1'b1;
               end
               FUNC_HLT: begin
                  ctrl_o.halt = 1'b1;
               end
               default: begin
                  illegal_o = 1'b1;
               end
            endcase
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase

      if (illegal_o) begin
         ctrl_o = '0;
      end else begin
         ctrl_o.alu_op = opcode;
      end
      ctrl_o.illegal = illegal_o;
      ctrl_o.valid   = 1'b1;
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control path: decodes in ID, carries control through EX/MEM/WB,
// applies freeze/flush/stall/halt rules and counts retired instructions.
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int unsigned WORD_SIZE         = 16,
   parameter int unsigned CNT_WIDTH         = 16,
   parameter int unsigned BUBBLE_ON_ILLEGAL = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [WORD_SIZE-1:0] inst_i,
   input  logic                 inst_valid_i,
   input  logic                 hazard_stall_i,
   input  logic                 freeze_i,
   input  logic                 flush_i,
   output logic                 ex_alu_src_o,
   output logic [1:0]           ex_reg_dst_o,
   output logic [1:0]           ex_pc_src_o,
   output logic [3:0]           ex_alu_op_o,
   output logic [5:0]           ex_func_o,
   output logic                 ex_valid_o,
   output logic                 mem_read_o,
   output logic                 mem_write_o,
   output logic                 mem_valid_o,
   output logic                 wb_reg_write_o,
   output logic                 wb_mem_to_reg_o,
   output logic                 wb_link_o,
   output logic                 wb_wwd_o,
   output logic                 wb_valid_o,
   output logic                 is_halted_o,
   output logic                 illegal_inst_o,
   output logic [CNT_WIDTH-1:0] retired_o
);

   ex_ctrl_t  dec_ctrl;
   logic      dec_illegal;
   ex_ctrl_t  id_ctrl;

   ex_ctrl_t  ex_d, ex_q;
   mem_ctrl_t mem_d, mem_q;
   wb_ctrl_t  wb_d, wb_q;
   logic      halt_pending_d, halt_pending_q;
   logic      is_halted_d, is_halted_q;
   logic      illegal_d, illegal_q;
   logic [CNT_WIDTH-1:0] retired_d, retired_q;

   ctrl_decode #(
      .WORD_SIZE(WORD_SIZE)
   ) u_decode (
      .inst_i   (inst_i),
      .ctrl_o   (dec_ctrl),
      .illegal_o(dec_illegal)
   );

   // An illegal word either travels as a flagged bubble or as a counted NOP.
   always_comb begin
      id_ctrl = dec_ctrl;
      if (dec_illegal && (BUBBLE_ON_ILLEGAL != 0)) begin
         id_ctrl.valid = 1'b0;
      end
   end

   always_comb begin
      ex_d           = ex_q;
      mem_d          = mem_q;
      wb_d           = wb_q;
      halt_pending_d = halt_pending_q;
      is_halted_d    = is_halted_q;
      illegal_d      = illegal_q;
      retired_d      = retired_q;

      if (!freeze_i) begin
         if (is_halted_q) begin
            ex_d  = '0;
            mem_d = '0;
            wb_d  = '0;
         end else begin
            if (flush_i || hazard_stall_i || !inst_valid_i || halt_pending_q) begin
               ex_d = '0;
            end else begin
               ex_d = id_ctrl;
            end

            mem_d.mem_read   = ex_q.mem_read;
            mem_d.mem_write  = ex_q.mem_write;
            mem_d.reg_write  = ex_q.reg_write;
            mem_d.mem_to_reg = ex_q.mem_to_reg;
            mem_d.link       = ex_q.link;
            mem_d.wwd        = ex_q.wwd;
            mem_d.halt       = ex_q.halt;
            mem_d.illegal    = ex_q.illegal;
            mem_d.valid      = ex_q.valid;

            wb_d.reg_write   = mem_q.reg_write;
            wb_d.mem_to_reg  = mem_q.mem_to_reg;
            wb_d.link        = mem_q.link;
            wb_d.wwd         = mem_q.wwd;
            wb_d.halt        = mem_q.halt;
            wb_d.illegal     = mem_q.illegal;
            wb_d.valid       = mem_q.valid;
         end

         halt_pending_d = halt_pending_q | (ex_d.valid & ex_d.halt);
         is_halted_d    = is_halted_q | (wb_q.valid & wb_q.halt);
         illegal_d      = illegal_q | wb_q.illegal;

         if (wb_q.valid && (retired_q != {CNT_WIDTH{1'b1}})) begin
            retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ex_q           <= '0;
         mem_q          <= '0;
         wb_q           <= '0;
         halt_pending_q <= 1'b0;
         is_halted_q    <= 1'b0;
         illegal_q      <= 1'b0;
         retired_q      <= '0;
      end else begin
         ex_q           <= ex_d;
         mem_q          <= mem_d;
         wb_q           <= wb_d;
         halt_pending_q <= halt_pending_d;
         is_halted_q    <= is_halted_d;
         illegal_q      <= illegal_d;
         retired_q      <= retired_d;
      end
   end

   assign ex_alu_src_o    = ex_q.alu_src;
   assign ex_reg_dst_o    = ex_q.reg_dst;
   assign ex_pc_src_o     = ex_q.pc_src;
   assign ex_alu_op_o     = ex_q.alu_op;
   assign ex_func_o       = ex_q.func;
   assign ex_valid_o      = ex_q.valid;
   assign mem_read_o      = mem_q.mem_read;
   assign mem_write_o     = mem_q.mem_write;
   assign mem_valid_o     = mem_q.valid;
   assign wb_reg_write_o  = wb_q.reg_write;
   assign wb_mem_to_reg_o = wb_q.mem_to_reg;
   assign wb_link_o       = wb_q.link;
   assign wb_wwd_o        = wb_q.wwd;
   assign wb_valid_o      = wb_q.valid;
   assign is_halted_o     = is_halted_q;
   assign illegal_inst_o  = illegal_q;
   assign retired_o       = retired_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: two instances (default, and 4-bit counter with illegal-as-NOP)
// checked every cycle against an instruction-level model, plus directed literal checks.
module tb_ctrl_pipe;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic [15:0] inst       = '0;
   logic        inst_valid = 1'b0;
   logic        hazard     = 1'b0;
   logic        freeze     = 1'b0;
   logic        flush      = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic       ex_alu_src    [2];
   logic [1:0] ex_reg_dst    [2];
   logic [1:0] ex_pc_src     [2];
   logic [3:0] ex_alu_op     [2];
   logic [5:0] ex_func       [2];
   logic       ex_valid      [2];
   logic       mem_read      [2];
   logic       mem_write     [2];
   logic       mem_valid     [2];
   logic       wb_reg_write  [2];
   logic       wb_mem_to_reg [2];
   logic       wb_link       [2];
   logic       wb_wwd        [2];
   logic       wb_valid      [2];
   logic       is_halted     [2];
   logic       illegal_inst  [2];
   logic [15:0] retired_a;
   logic [3:0]  retired_b;

   always #5 clk = ~clk;

   ctrl_pipe u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .inst_i(inst), .inst_valid_i(inst_valid),
      .hazard_stall_i(hazard), .freeze_i(freeze), .flush_i(flush),
      .ex_alu_src_o(ex_alu_src[0]), .ex_reg_dst_o(ex_reg_dst[0]), .ex_pc_src_o(ex_pc_src[0]),
      .ex_alu_op_o(ex_alu_op[0]), .ex_func_o(ex_func[0]), .ex_valid_o(ex_valid[0]),
      .mem_read_o(mem_read[0]), .mem_write_o(mem_write[0]), .mem_valid_o(mem_valid[0]),
      .wb_reg_write_o(wb_reg_write[0]), .wb_mem_to_reg_o(wb_mem_to_reg[0]),
      .wb_link_o(wb_link[0]), .wb_wwd_o(wb_wwd[0]), .wb_valid_o(wb_valid[0]),
      .is_halted_o(is_halted[0]), .illegal_inst_o(illegal_inst[0]), .retired_o(retired_a)
   );

   ctrl_pipe #(
      .WORD_SIZE(16), .CNT_WIDTH(4), .BUBBLE_ON_ILLEGAL(0)
   ) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .inst_i(inst), .inst_valid_i(inst_valid),
      .hazard_stall_i(hazard), .freeze_i(freeze), .flush_i(flush),
      .ex_alu_src_o(ex_alu_src[1]), .ex_reg_dst_o(ex_reg_dst[1]), .ex_pc_src_o(ex_pc_src[1]),
      .ex_alu_op_o(ex_alu_op[1]), .ex_func_o(ex_func[1]), .ex_valid_o(ex_valid[1]),
      .mem_read_o(mem_read[1]), .mem_write_o(mem_write[1]), .mem_valid_o(mem_valid[1]),
      .wb_reg_write_o(wb_reg_write[1]), .wb_mem_to_reg_o(wb_mem_to_reg[1]),
      .wb_link_o(wb_link[1]), .wb_wwd_o(wb_wwd[1]), .wb_valid_o(wb_valid[1]),
      .is_halted_o(is_halted[1]), .illegal_inst_o(illegal_inst[1]), .retired_o(retired_b)
   );

   // ---------------- instruction-level reference model ----------------
   typedef struct packed {
      logic       alu_src;
      logic [1:0] reg_dst;
      logic [1:0] pc_src;
      logic [3:0] alu_op;
      logic [5:0] func;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       link;
      logic       wwd;
   } fields_t;

   // A pipeline slot holds the instruction word itself plus its status.
   typedef struct packed {
      logic        v;
      logic        ill;
      logic [15:0] w;
   } slot_t;

   slot_t m_ex [2];
   slot_t m_mem[2];
   slot_t m_wb [2];
   bit    m_pend  [2];
   bit    m_halted[2];
   bit    m_ill   [2];
   int    m_cnt   [2];

   function automatic bit legal(logic [15:0] w);
      int op = int'(w[15:12]);
      int fn = int'(w[5:0]);
      return (op <= 10) ||
             (op == 15 && (fn <= 7 || fn == 25 || fn == 26 || fn == 28 || fn == 29));
   endfunction

   function automatic bit is_hlt(logic [15:0] w);
      return (w[15:12] == 4'hF) && (w[5:0] == 6'd29);
   endfunction

   function automatic fields_t spec_ctrl(logic [15:0] w);
      fields_t f  = '0;
      int      op = int'(w[15:12]);
      int      fn = int'(w[5:0]);
      f.alu_op = w[15:12];
      if (op >= 4 && op <= 6) begin
         f.alu_src = 1'b1; f.reg_write = 1'b1;
      end else if (op == 7) begin
         f.alu_src = 1'b1; f.mem_read = 1'b1; f.mem_to_reg = 1'b1; f.reg_write = 1'b1;
      end else if (op == 8) begin
         f.alu_src = 1'b1; f.mem_write = 1'b1;
      end else if (op == 9) begin
         f.pc_src = 2'd1;
      end else if (op == 10) begin
         f.pc_src = 2'd1; f.reg_dst = 2'd2; f.link = 1'b1; f.reg_write = 1'b1;
      end else if (op == 15) begin
         f.func = w[5:0];
         if (fn <= 7) begin
            f.reg_dst = 2'd1; f.reg_write = 1'b1;
         end else if (fn == 25) begin
            f.pc_src = 2'd2;
         end else if (fn == 26) begin
            f.pc_src = 2'd2; f.reg_dst = 2'd2; f.link = 1'b1; f.reg_write = 1'b1;
         end else if (fn == 28) begin
            f.wwd = 1'b1;
         end
      end
      return f;
   endfunction

   function automatic fields_t slot_fields(slot_t s);
      if (!s.v || s.ill) return '0;
      return spec_ctrl(s.w);
   endfunction

   function automatic logic [25:0] expected_vec(int k);
      fields_t fe = slot_fields(m_ex[k]);
      fields_t fm = slot_fields(m_mem[k]);
      fields_t fw = slot_fields(m_wb[k]);
      return {fe.alu_src, fe.reg_dst, fe.pc_src, fe.alu_op, fe.func, m_ex[k].v,
              fm.mem_read, fm.mem_write, m_mem[k].v,
              fw.reg_write, fw.mem_to_reg, fw.link, fw.wwd, m_wb[k].v,
              m_halted[k], m_ill[k]};
   endfunction

   function automatic logic [25:0] actual_vec(int k);
      return {ex_alu_src[k], ex_reg_dst[k], ex_pc_src[k], ex_alu_op[k], ex_func[k], ex_valid[k],
              mem_read[k], mem_write[k], mem_valid[k],
              wb_reg_write[k], wb_mem_to_reg[k], wb_link[k], wb_wwd[k], wb_valid[k],
              is_halted[k], illegal_inst[k]};
   endfunction

   function automatic int retired_of(int k);
      return (k == 0) ? int'(retired_a) : int'(retired_b);
   endfunction

   task automatic model_step(input int k);
      slot_t bub = '0;
      bit    leave_h;
      int    cmax = (k == 0) ? 65535 : 15;
      if (!rst_n) begin
         m_ex[k] = bub; m_mem[k] = bub; m_wb[k] = bub;
         m_pend[k] = 0; m_halted[k] = 0; m_ill[k] = 0; m_cnt[k] = 0;
         return;
      end
      if (freeze) return;
      leave_h = m_wb[k].v && is_hlt(m_wb[k].w);
      if (m_wb[k].v && m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
      if (m_wb[k].ill) m_ill[k] = 1;
      if (m_halted[k]) begin
         m_ex[k] = bub; m_mem[k] = bub; m_wb[k] = bub;
      end else begin
         m_wb[k]  = m_mem[k];
         m_mem[k] = m_ex[k];
         if (flush || hazard || !inst_valid || m_pend[k]) begin
            m_ex[k] = bub;
         end else begin
            m_ex[k].w   = inst;
            m_ex[k].ill = !legal(inst);
            m_ex[k].v   = !(m_ex[k].ill && k == 0);
         end
         if (m_ex[k].v && is_hlt(m_ex[k].w)) m_pend[k] = 1;
      end
      if (leave_h) m_halted[k] = 1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: advance model on each edge, check every output shortly after.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("outputs dut%0d", k), 32'(actual_vec(k)), 32'(expected_vec(k)));
         check($sformatf("retired dut%0d", k), 32'(retired_of(k)), 32'(m_cnt[k]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [15:0] i, input logic v, input logic st, input logic fr,
                        input logic fl);
      inst = i; inst_valid = v; hazard = st; freeze = fr; flush = fl;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s outputs dut%0d", tag, k), 32'(actual_vec(k)), 32'd0);
         check($sformatf("%s retired dut%0d", tag, k), 32'(retired_of(k)), 32'd0);
      end
   endtask

   function automatic logic [15:0] rand_inst();
      int          sel = $urandom_range(0, 39);
      logic [15:0] w   = 16'($urandom);
      if (sel == 0) return 16'hF01D;
      if (sel < 4) begin
         w[15:12] = 4'($urandom_range(11, 14));
      end else if (sel < 20) begin
         w[15:12] = 4'($urandom_range(0, 10));
      end else if (sel < 37) begin
         w[15:12] = 4'hF;
         case ($urandom_range(0, 10))
            8:       w[5:0] = 6'd25;
            9:       w[5:0] = 6'd26;
            10:      w[5:0] = 6'd28;
            default: w[5:0] = 6'($urandom_range(0, 7));
         endcase
      end else begin
         w[15:12] = 4'hF;
         w[5:0]   = 6'($urandom_range(8, 24));
      end
      return w;
   endfunction

   initial begin
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      drive(16'h7123, 1, 0, 0, 0);                       // LWD enters EX
      check("lwd ex_valid", 32'(ex_valid[0]), 1);
      check("lwd ex_alu_src", 32'(ex_alu_src[0]), 1);
      drive(16'hF000, 1, 1, 0, 0);                       // stall: EX bubble
      check("stall ex_valid", 32'(ex_valid[0]), 0);
      check("lwd mem_read", 32'(mem_read[0]), 1);
      drive(16'hF000, 1, 0, 0, 0);                       // ADD enters EX, LWD in WB
      check("lwd wb_mem_to_reg", 32'(wb_mem_to_reg[0]), 1);
      check("lwd wb_reg_write", 32'(wb_reg_write[0]), 1);
      check("add ex_reg_dst", 32'(ex_reg_dst[0]), 1);
      drive(16'hA005, 1, 0, 0, 0);                       // JAL enters EX
      check("lwd retired", 32'(retired_a), 1);
      check("jal ex_pc_src", 32'(ex_pc_src[0]), 1);
      check("jal ex_reg_dst", 32'(ex_reg_dst[0]), 2);
      drive(16'hF000, 1, 0, 0, 1);                       // flush kills ADD
      check("flush ex_valid", 32'(ex_valid[0]), 0);
      drive(16'h0000, 0, 0, 0, 0);
      check("jal wb_link", 32'(wb_link[0]), 1);
      check("add retired", 32'(retired_a), 2);
      repeat (5) drive(16'hF000, 1, 0, 1, 0);
      check("freeze retired", 32'(retired_a), 2);
      check("freeze wb_link", 32'(wb_link[0]), 1);
      check("freeze ex_valid", 32'(ex_valid[0]), 0);
      drive(16'hF000, 1, 0, 0, 0);
      check("unfreeze retired", 32'(retired_a), 3);
      check("unfreeze ex_valid", 32'(ex_valid[0]), 1);
      drive(16'hB000, 1, 0, 0, 0);                       // illegal opcode
      check("illegal bubble ex_valid", 32'(ex_valid[0]), 0);
      check("illegal nop ex_valid", 32'(ex_valid[1]), 1);
      repeat (3) drive(16'h0000, 0, 0, 0, 0);
      check("illegal flag a", 32'(illegal_inst[0]), 1);
      check("illegal flag b", 32'(illegal_inst[1]), 1);
      check("illegal retired a", 32'(retired_a), 4);
      check("illegal retired b", 32'(retired_b), 5);
      drive(16'hF01D, 1, 0, 0, 0);                       // HLT enters EX
      check("hlt ex_valid", 32'(ex_valid[0]), 1);
      drive(16'h4001, 1, 0, 0, 0);
      check("post-hlt adi bubble", 32'(ex_valid[0]), 0);
      drive(16'h4001, 1, 0, 0, 0);
      check("halt not yet", 32'(is_halted[0]), 0);
      check("pre-halt retired", 32'(retired_a), 4);
      drive(16'h4001, 1, 0, 0, 0);
      check("halted", 32'(is_halted[0]), 1);
      check("hlt retired", 32'(retired_a), 5);
      drive(16'h4001, 1, 0, 0, 0);
      check("halted retired hold", 32'(retired_a), 5);

      // Async reset mid-stream with an LWD in MEM.
      rst_n = 1'b0;
      drive(16'h0000, 0, 0, 0, 0);
      rst_n = 1'b1;
      drive(16'h7123, 1, 0, 0, 0);
      drive(16'hF000, 1, 0, 0, 0);
      check("lwd in mem", 32'(mem_read[0]), 1);
      #3 rst_n = 1'b0;
      #1 check_all_zero("async reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int c = 0; c < 3000; c++) begin
         if ((m_halted[0] && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            drive(16'h0000, 0, 0, 0, 0);
            rst_n = 1'b1;
         end
         drive(rand_inst(), 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised successor to the combinational decoder.
- Decodes each 16-bit instruction in ID and carries a registered control word through the EX, MEM and WB stage registers.
- Applies hazard-bubble, flush and cache-freeze rules in one place, latches halt, and counts retired instructions.
- Sits between the IF/ID register and the datapath of the cached pipelined CPU.

Parameters:
- WORD_SIZE, 16, instruction width; opcode is [WORD_SIZE-1:WORD_SIZE-4], func is [5:0].
- CNT_WIDTH, 16, width of the retired-instruction counter.
- BUBBLE_ON_ILLEGAL, 1: 1 = an illegal opcode/func becomes a bubble; 0 = it decodes as a NOP but still counts as retired.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- inst, input, WORD_SIZE, instruction held in the IF/ID register.
- inst_valid, input, 1, the IF/ID register holds a real instruction.
- hazard_stall, input, 1, load-use/RAW stall: ID holds and EX receives a bubble.
- freeze, input, 1, i-cache or d-cache miss: every stage register holds.
- flush, input, 1, branch/jump redirect: the ID instruction is killed.
- ex_alu_src, ex_reg_dst[1:0], ex_pc_src[1:0], ex_alu_op[3:0], ex_func[5:0], ex_valid, outputs, EX control.
- mem_read, mem_write, mem_valid, outputs, MEM control.
- wb_reg_write, wb_mem_to_reg, wb_link, wb_wwd, wb_valid, outputs, WB control.
- is_halted, output, 1, sticky halt flag.
- illegal_inst, output, 1, sticky flag for an undefined opcode/func reaching WB.
- retired, output, CNT_WIDTH, count of valid instructions that left WB.

Behaviour:
- Reset (async, reset_n=0): all outputs 0 and all stage valids 0. This includes pc_src/reg_dst; nothing is left as X.
- Decode:
  - R-type arithmetic (ADD..SHR): reg_dst=1, reg_write=1.
  - ADI/ORI/LHI: alu_src=1, reg_dst=0, reg_write=1.
  - LWD: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
  - SWD: alu_src=1, mem_write=1.
  - BNE/BEQ/BGZ/BLZ: pc_src=0.
  - JMP: pc_src=1.
  - JAL: pc_src=1, reg_dst=2, link=1, reg_write=1.
  - JPR: pc_src=2.
  - JRL: pc_src=2, reg_dst=2, link=1, reg_write=1.
  - WWD: wwd=1.
  - HLT: halt bit set.
  - Any field not listed for an instruction is 0.
- Bubble: valid=0 with all enables 0 (reg_write, mem_read, mem_write, wwd, link, halt).
- Per-edge priority: reset > freeze > flush > hazard_stall > normal advance.
  - freeze=1: ID/EX, EX/MEM and MEM/WB all hold; retired holds; is_halted holds.
  - flush=1: EX receives a bubble; MEM and WB advance normally.
  - hazard_stall=1: EX receives a bubble; MEM and WB advance. The external IF/ID register holds; this block does not re-register inst.
  - Normal advance: EX receives decode(inst) when inst_valid=1, otherwise a bubble.
- Latency: an instruction present at edge N has its controls on ex_* after N, mem_* after N+1, wb_* after N+2, assuming no freeze.
- Halt:
  - halt_pending is set when HLT enters EX. While it is set, every new ID instruction becomes a bubble.
  - is_halted is set on the edge HLT leaves WB and is sticky until reset.
  - After is_halted, all stages flush to bubbles.
  - A flush on the HLT's own ID cycle cancels it.
- retired: increments on each non-frozen edge with wb_valid=1. HLT counts. It saturates at all-ones and does not wrap.
- illegal_inst: set when an illegal-decoded instruction leaves WB; sticky until reset.
- Reset asserted mid-operation clears everything immediately, including a pending halt.
- freeze deasserting together with flush asserted: flush applies on that same edge.

Decomposition:
- Opcode and func constants (OPCODE_*, FUNC_*), the control-word field layout, and the PC_SRC/REG_DST encodings go in the shared opcodes include.
- One sub-module, ctrl_decode: purely combinational, inst -> control word plus illegal bit.
- ctrl_pipe owns the stage registers, the halt/flush/freeze logic and the counter.

Test Plan:
- Reset: hold reset_n=0 mid-stream with LWD in MEM → all outputs 0 immediately; retired=0.
- LWD (0x7xxx), then hazard_stall for 1 cycle → ex_valid=0 for one cycle; the LWD reaches WB with mem_to_reg=1, reg_write=1; retired +1.
- JAL (0xAxxx) followed by flush → ex_pc_src=1, ex_reg_dst=2, ex_link=1; the next ID instruction appears as a bubble in EX.
- ADD stream with freeze=1 for 5 cycles → all ex_/mem_/wb_ outputs and retired are constant across the freeze; normal advance resumes the following edge.
- HLT (0xF01D) followed by three ADIs → the ADIs appear as bubbles; is_halted=1 three edges after HLT enters EX; retired counts only instructions before HLT plus HLT.
- Opcode 0xB with BUBBLE_ON_ILLEGAL=1 → no write enables assert; illegal_inst=1 once the bubble leaves WB; retired does not increment. Repeat with CNT_WIDTH=4 and 20 ADDs → retired saturates at 15.
